irq_cond: RTL and testbench
===========================

// Module: irq_cond
// PURPOSE
//  Interrupt-source conditioner sitting directly upstream of irq_ctrl; irq_o[n] drives interrupt<n>_i.
//  Per line: synchronises an asynchronous raw request, applies polarity, debounces, and presents it
//  as a level or a one-cycle edge pulse. Configured over the same cfg_* register handshake as other
//  peripherals.
// PARAMETERS
//  NUM_IRQ      4    number of lines (fixed 4 for irq_ctrl; register fields sized for <=8)
//  SYNC_STAGES  2    synchroniser flops per line (>=2)
//  DB_W         16   debounce counter width
// PORTS
//  clk_i          in   1      clock
//  rst_i          in   1      reset, asynchronous, active-high
//  cfg_awvalid_i  in   1      write address valid
//  cfg_awaddr_i   in   32     write address ([7:0] decoded)
//  cfg_wvalid_i   in   1      write data valid
//  cfg_wdata_i    in   32     write data
//  cfg_wstrb_i    in   4      byte strobes (ignored; full-word writes only)
//  cfg_bready_i   in   1      write response ready
//  cfg_arvalid_i  in   1      read address valid
//  cfg_araddr_i   in   32     read address ([7:0] decoded)
//  cfg_rready_i   in   1      read data ready
//  irq_raw_i      in   NUM_IRQ  asynchronous raw requests
//  cfg_awready_o / cfg_wready_o / cfg_bvalid_o / cfg_arready_o / cfg_rvalid_o  out 1  handshakes
//  cfg_bresp_o    out  2      always 2'b00
//  cfg_rdata_o    out  32     read data, registered
//  cfg_rresp_o    out  2      always 2'b00
//  irq_o          out  NUM_IRQ  conditioned requests to irq_ctrl
// BEHAVIOUR
//  Reset: all outputs 0; all registers, sync flops, counters and filtered levels 0.
//  Registers:
//   0x00 CTRL  RW  [3:0] edge mode (1 = pulse), [11:8] invert, [19:16] enable
//   0x04 DBNC  RW  [DB_W-1:0] debounce count D
//   0x08 STAT  RO  [3:0] filtered level, [11:8] post-sync raw
//  Unmapped reads return 0; unmapped writes are ignored.
//  Write handshake: awready = wready = awvalid & wvalid & ~bvalid; the register updates on the
//   accept edge; bvalid rises the next cycle and holds until bready.
//  Read handshake: arready = arvalid & ~rvalid & ~(write accepted this cycle); write has priority on
//   collision. rdata is captured on accept; rvalid rises the next cycle; rdata is stable until rready.
//  Line pipeline:
//   sync chain -> s = sync ^ invert.
//   If s == filt: cnt <= 0.
//   Else if cnt >= D: filt <= s and cnt <= 0.
//   Else: cnt++.
//  D changed mid-count: ">=" forces an immediate update if cnt already exceeds the new D.
//   No wrap, because cnt stops at D.
//  Output register:
//   level mode: irq_o = filt & en.
//   edge mode:  irq_o = filt & ~filt_d & en, where filt_d is filt delayed one cycle.
//  Latency from raw transition to irq_o: SYNC_STAGES + D + 2 cycles.
//  Glitch rule: a raw pulse shorter than D+1 synchronised cycles never reaches irq_o.
//  Disabled line: filt and filt_d still track; irq_o = 0. Enabling never produces a stale edge pulse.
//   In level mode, enabling asserts irq_o next cycle if filt = 1.
//  Invert toggled: s flips and is debounced like any input change. In edge mode this yields a pulse
//   only if filt rises.
//  CTRL write and edge on the same cycle: the new CTRL takes effect on the following cycle's
//   computation.
//  Reset mid-operation clears everything asynchronously; irq_o drops immediately.
// STRUCTURE
//  irq_cond_def.v: register offsets (IRQ_COND_CTRL/DBNC/STAT) and field ranges (_R macros), defaults.
//  Sub-module irq_cond_line: sync chain, invert, debounce counter, edge/level output, one per line via
//   generate. The top holds the register file and the cfg handshake.
// TESTING
//  1 Reset, D=0, level, en=1; raw0 0->1 at cycle 0 -> irq_o[0]=1 at cycle 4; STAT reads 0x101.
//  2 D=5, raw1 high for 4 cycles -> irq_o[1] stays 0. Raw1 held high -> irq_o[1]=1 at SYNC+D+2 = 9.
//  3 Edge mode line2, raw2 held high 20 cycles -> irq_o[2] is exactly one 1-cycle pulse; no pulse on
//    release.
//  4 Invert line3, raw3=0, en=1, level -> irq_o[3]=1. en=0 -> irq_o[3]=0 next cycle.
//    Re-enable in edge mode -> no pulse.
//  5 awvalid+wvalid and arvalid same cycle -> write accepted, arready=0; read accepted the next cycle.
//    bvalid held 3 cycles until bready.
//  6 Assert rst_i while cnt mid-count and irq_o=1 -> irq_o=0 asynchronously. After release, CTRL=0
//    and DBNC=0 read back.

Source files
------------

// File: rtl/irq_cond_pkg.sv
// Shared register map, field positions and per-line configuration type for the interrupt conditioner.
package irq_cond_pkg;

   localparam logic [7:0] ADDR_CTRL = 8'h00;
   localparam logic [7:0] ADDR_DBNC = 8'h04;
   localparam logic [7:0] ADDR_STAT = 8'h08;

   // CTRL and STAT fields are 8 bits wide so the map holds for up to 8 lines.
   localparam int CTRL_EDGE_LSB = 0;
   localparam int CTRL_INV_LSB  = 8;
   localparam int CTRL_EN_LSB   = 16;
   localparam int STAT_FILT_LSB = 0;
   localparam int STAT_RAW_LSB  = 8;

   typedef enum logic [1:0] {
      REG_CTRL,
      REG_DBNC,
      REG_STAT,
      REG_NONE
   } reg_sel_e;

   typedef struct packed {
      logic edge_mode;
      logic invert;
      logic enable;
   } line_cfg_t;

   function automatic reg_sel_e reg_decode(input logic [7:0] addr);
      case (addr)
         ADDR_CTRL: reg_decode = REG_CTRL;
         ADDR_DBNC: reg_decode = REG_DBNC;
         ADDR_STAT: reg_decode = REG_STAT;
         default:   reg_decode = REG_NONE;
      endcase
   endfunction

endpackage

// File: rtl/irq_cond_line.sv
// One conditioned interrupt line: synchroniser, polarity, debounce filter and level/pulse output register.
module irq_cond_line
   import irq_cond_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int DB_W        = 16
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            raw_i,
   input  line_cfg_t       cfg_i,
   input  logic [DB_W-1:0] dbnc_i,
   output logic            sync_o,
   output logic            filt_o,
   output logic            irq_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [DB_W-1:0]        cnt_q;
   logic                   filt_q;
   logic                   filt_d_q;
   logic                   irq_q;
   logic                   s;

   assign s = sync_q[SYNC_STAGES-1] ^ cfg_i.invert;

   // cnt never passes dbnc_i, so ">=" only matters when dbnc_i is lowered mid-count.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q   <= '0;
         cnt_q    <= '0;
         filt_q   <= 1'b0;
         filt_d_q <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         sync_q   <= {sync_q[SYNC_STAGES-2:0], raw_i};
         filt_d_q <= filt_q;
         if (s == filt_q) begin
            cnt_q <= '0;
         end else if (cnt_q >= dbnc_i) begin
            filt_q <= s;
            cnt_q  <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
         // filt_d tracks while disabled, so enabling cannot release a stale edge.
         irq_q <= cfg_i.enable & filt_q & (cfg_i.edge_mode ? ~filt_d_q : 1'b1);
      end
   end

   assign sync_o = sync_q[SYNC_STAGES-1];
   assign filt_o = filt_q;
   assign irq_o  = irq_q;

endmodule

// File: rtl/irq_cond.sv
// Interrupt-source conditioner: cfg register file and handshake, plus one irq_cond_line per request.
module irq_cond
   import irq_cond_pkg::*;
#(
   parameter int NUM_IRQ     = 4,
   parameter int SYNC_STAGES = 2,
   parameter int DB_W        = 16
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               cfg_awvalid_i,
   input  logic [31:0]        cfg_awaddr_i,
   input  logic               cfg_wvalid_i,
   input  logic [31:0]        cfg_wdata_i,
   input  logic [3:0]         cfg_wstrb_i,
   input  logic               cfg_bready_i,
   input  logic               cfg_arvalid_i,
   input  logic [31:0]        cfg_araddr_i,
   input  logic               cfg_rready_i,
   input  logic [NUM_IRQ-1:0] irq_raw_i,
   output logic               cfg_awready_o,
   output logic               cfg_wready_o,
   output logic               cfg_bvalid_o,
   output logic [1:0]         cfg_bresp_o,
   output logic               cfg_arready_o,
   output logic               cfg_rvalid_o,
   output logic [31:0]        cfg_rdata_o,
   output logic [1:0]         cfg_rresp_o,
   output logic [NUM_IRQ-1:0] irq_o
);

   logic [NUM_IRQ-1:0] edge_q;
   logic [NUM_IRQ-1:0] inv_q;
   logic [NUM_IRQ-1:0] en_q;
   logic [DB_W-1:0]    dbnc_q;
   logic               bvalid_q;
   logic               rvalid_q;
   logic [31:0]        rdata_q;
   logic               wr_acc;
   logic               rd_acc;
   logic [31:0]        rd_word;
   logic [NUM_IRQ-1:0] sync_v;
   logic [NUM_IRQ-1:0] filt_v;
   logic               unused_ok;

   // Writes win a same-cycle collision; the read is taken once the write has gone.
   assign wr_acc = cfg_awvalid_i & cfg_wvalid_i & ~bvalid_q;
   assign rd_acc = cfg_arvalid_i & ~rvalid_q & ~wr_acc;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         edge_q   <= '0;
         inv_q    <= '0;
         en_q     <= '0;
         dbnc_q   <= '0;
         bvalid_q <= 1'b0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         if (wr_acc) begin
            case (reg_decode(cfg_awaddr_i[7:0]))
               REG_CTRL: begin
                  edge_q <= cfg_wdata_i[CTRL_EDGE_LSB +: NUM_IRQ];
                  inv_q  <= cfg_wdata_i[CTRL_INV_LSB +: NUM_IRQ];
                  en_q   <= cfg_wdata_i[CTRL_EN_LSB +: NUM_IRQ];
               end
               REG_DBNC: dbnc_q <= cfg_wdata_i[DB_W-1:0];
               default: ;
            endcase
            bvalid_q <= 1'b1;
         end else if (cfg_bready_i) begin
            bvalid_q <= 1'b0;
         end

         if (rd_acc) begin
            rdata_q  <= rd_word;
            rvalid_q <= 1'b1;
         end else if (cfg_rready_i) begin
            rvalid_q <= 1'b0;
         end
      end
   end

   always_comb begin
      rd_word = '0;
      case (reg_decode(cfg_araddr_i[7:0]))
         REG_CTRL: begin
            rd_word[CTRL_EDGE_LSB +: NUM_IRQ] = edge_q;
            rd_word[CTRL_INV_LSB +: NUM_IRQ]  = inv_q;
            rd_word[CTRL_EN_LSB +: NUM_IRQ]   = en_q;
         end
         REG_DBNC: rd_word[DB_W-1:0] = dbnc_q;
         REG_STAT: begin
            rd_word[STAT_FILT_LSB +: NUM_IRQ] = filt_v;
            rd_word[STAT_RAW_LSB +: NUM_IRQ]  = sync_v;
         end
         default: rd_word = '0;
      endcase
   end

   for (genvar g = 0; g < NUM_IRQ; g++) begin : g_line
      line_cfg_t line_cfg;
      assign line_cfg = '{edge_mode: edge_q[g], invert: inv_q[g], enable: en_q[g]};

      irq_cond_line #(
         .SYNC_STAGES (SYNC_STAGES),
         .DB_W        (DB_W)
      ) u_line (
         .clk_i  (clk_i),
         .rst_i  (rst_i),
         .raw_i  (irq_raw_i[g]),
         .cfg_i  (line_cfg),
         .dbnc_i (dbnc_q),
         .sync_o (sync_v[g]),
         .filt_o (filt_v[g]),
         .irq_o  (irq_o[g])
      );
   end

   assign cfg_awready_o = wr_acc;
   assign cfg_wready_o  = wr_acc;
   assign cfg_bvalid_o  = bvalid_q;
   assign cfg_bresp_o   = 2'b00;
   assign cfg_arready_o = rd_acc;
   assign cfg_rvalid_o  = rvalid_q;
   assign cfg_rdata_o   = rdata_q;
   assign cfg_rresp_o   = 2'b00;

   // Full-word writes only and an 8-bit decode leave these bits without a consumer.
   assign unused_ok = ^{cfg_wstrb_i, cfg_awaddr_i, cfg_araddr_i, cfg_wdata_i};

endmodule

// File: tb/tb_irq_cond.sv
// Directed bench for irq_cond: latency, debounce, edge/level, enable, invert, handshake and reset.
module tb_irq_cond;
   import irq_cond_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        cfg_awvalid_i, cfg_wvalid_i, cfg_bready_i, cfg_arvalid_i, cfg_rready_i;
   logic [31:0] cfg_awaddr_i, cfg_wdata_i, cfg_araddr_i;
   logic [3:0]  cfg_wstrb_i;
   logic [3:0]  irq_raw_i;
   logic        cfg_awready_o, cfg_wready_o, cfg_bvalid_o, cfg_arready_o, cfg_rvalid_o;
   logic [1:0]  cfg_bresp_o, cfg_rresp_o;
   logic [31:0] cfg_rdata_o;
   logic [3:0]  irq_o;

   int n_checks = 0;
   int n_errors = 0;
   int hi_cnt [4];

   irq_cond dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .cfg_awvalid_i (cfg_awvalid_i),
      .cfg_awaddr_i  (cfg_awaddr_i),
      .cfg_wvalid_i  (cfg_wvalid_i),
      .cfg_wdata_i   (cfg_wdata_i),
      .cfg_wstrb_i   (cfg_wstrb_i),
      .cfg_bready_i  (cfg_bready_i),
      .cfg_arvalid_i (cfg_arvalid_i),
      .cfg_araddr_i  (cfg_araddr_i),
      .cfg_rready_i  (cfg_rready_i),
      .irq_raw_i     (irq_raw_i),
      .cfg_awready_o (cfg_awready_o),
      .cfg_wready_o  (cfg_wready_o),
      .cfg_bvalid_o  (cfg_bvalid_o),
      .cfg_bresp_o   (cfg_bresp_o),
      .cfg_arready_o (cfg_arready_o),
      .cfg_rvalid_o  (cfg_rvalid_o),
      .cfg_rdata_o   (cfg_rdata_o),
      .cfg_rresp_o   (cfg_rresp_o),
      .irq_o         (irq_o)
   );

   always #5 clk_i = ~clk_i;

   // Cycles each line spends high, sampled mid-cycle.
   always @(negedge clk_i) begin
      for (int k = 0; k < 4; k++)
         if (irq_o[k]) hi_cnt[k] <= hi_cnt[k] + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   task automatic cfg_write(input logic [7:0] a, input logic [31:0] d);
      int n;
      cfg_awaddr_i  = {24'h0, a};
      cfg_wdata_i   = d;
      cfg_awvalid_i = 1'b1;
      cfg_wvalid_i  = 1'b1;
      cfg_bready_i  = 1'b1;
      #1;
      n = 0;
      while (!cfg_awready_o && n < 20) begin tick(); n++; end
      chk("aw_wait", (n < 20), 1);
      tick();
      cfg_awvalid_i = 1'b0;
      cfg_wvalid_i  = 1'b0;
      tick();
      cfg_bready_i  = 1'b0;
   endtask

   task automatic cfg_read(input logic [7:0] a, output logic [31:0] d);
      int n;
      cfg_araddr_i  = {24'h0, a};
      cfg_arvalid_i = 1'b1;
      cfg_rready_i  = 1'b0;
      #1;
      n = 0;
      while (!cfg_arready_o && n < 20) begin tick(); n++; end
      chk("ar_wait", (n < 20), 1);
      tick();
      cfg_arvalid_i = 1'b0;
      n = 0;
      while (!cfg_rvalid_o && n < 20) begin tick(); n++; end
      d = cfg_rdata_o;
      cfg_rready_i = 1'b1;
      tick();
      cfg_rready_i = 1'b0;
   endtask

   initial begin
      logic [31:0] rd;
      int          h;

      rst_i = 1'b1;
      cfg_awvalid_i = 0; cfg_wvalid_i = 0; cfg_bready_i = 0; cfg_arvalid_i = 0; cfg_rready_i = 0;
      cfg_awaddr_i = 0; cfg_wdata_i = 0; cfg_araddr_i = 0; cfg_wstrb_i = 4'hF;
      irq_raw_i = 4'h0;
      tick(3);
      chk("rst_irq", irq_o, 4'h0);
      chk("rst_bvalid", cfg_bvalid_o, 0);
      chk("rst_rvalid", cfg_rvalid_o, 0);
      chk("rst_rdata", cfg_rdata_o, 0);
      rst_i = 1'b0;
      tick();

      // 1: D=0 level mode, latency 4
      cfg_write(ADDR_CTRL, 32'h000F_0000);
      irq_raw_i[0] = 1'b1;
      tick(3);
      chk("t1_lat3", irq_o[0], 0);
      tick();
      chk("t1_lat4", irq_o[0], 1);
      cfg_read(ADDR_STAT, rd);
      chk("t1_stat", rd, 32'h101);

      // 2: D=5 glitch rejection then latency 9
      cfg_write(ADDR_DBNC, 32'd5);
      h = hi_cnt[1];
      irq_raw_i[1] = 1'b1;
      tick(4);
      irq_raw_i[1] = 1'b0;
      tick(15);
      chk("t2_glitch", hi_cnt[1] - h, 0);
      irq_raw_i[1] = 1'b1;
      tick(8);
      chk("t2_lat8", irq_o[1], 0);
      tick();
      chk("t2_lat9", irq_o[1], 1);
      cfg_read(ADDR_STAT, rd);
      chk("t2_stat", rd, 32'h303);

      // 3: edge mode on line 2, one pulse on rise, none on fall
      cfg_write(ADDR_CTRL, 32'h000F_0004);
      h = hi_cnt[2];
      irq_raw_i[2] = 1'b1;
      tick(20);
      chk("t3_rise_pulse", hi_cnt[2] - h, 1);
      h = hi_cnt[2];
      irq_raw_i[2] = 1'b0;
      tick(20);
      chk("t3_fall_pulse", hi_cnt[2] - h, 0);

      // 4: invert line 3, disable, re-enable in edge mode
      cfg_write(ADDR_CTRL, 32'h000F_0804);
      tick(12);
      chk("t4_inv_level", irq_o[3], 1);
      cfg_write(ADDR_CTRL, 32'h0007_0804);
      chk("t4_disabled", irq_o[3], 0);
      cfg_read(ADDR_STAT, rd);
      chk("t4_stat", rd, 32'h30B);
      h = hi_cnt[3];
      cfg_write(ADDR_CTRL, 32'h000F_080C);
      tick(10);
      chk("t4_no_stale", hi_cnt[3] - h, 0);
      cfg_read(ADDR_CTRL, rd);
      chk("t4_ctrl_rb", rd, 32'h000F_080C);

      // 5: write/read collision and held write response
      cfg_awaddr_i = 32'h4; cfg_wdata_i = 32'd3; cfg_awvalid_i = 1; cfg_wvalid_i = 1; cfg_bready_i = 0;
      cfg_araddr_i = 32'h4; cfg_arvalid_i = 1; cfg_rready_i = 0;
      #1;
      chk("t5_awready", cfg_awready_o, 1);
      chk("t5_arready_blk", cfg_arready_o, 0);
      tick();
      cfg_awvalid_i = 0; cfg_wvalid_i = 0;
      #1;
      chk("t5_bvalid1", cfg_bvalid_o, 1);
      chk("t5_arready_go", cfg_arready_o, 1);
      tick();
      cfg_arvalid_i = 0;
      chk("t5_rvalid", cfg_rvalid_o, 1);
      chk("t5_rdata", cfg_rdata_o, 3);
      chk("t5_bvalid2", cfg_bvalid_o, 1);
      tick();
      chk("t5_bvalid3", cfg_bvalid_o, 1);
      chk("t5_rdata_hold", cfg_rdata_o, 3);
      cfg_bready_i = 1; cfg_rready_i = 1;
      tick();
      chk("t5_bvalid_clr", cfg_bvalid_o, 0);
      chk("t5_rvalid_clr", cfg_rvalid_o, 0);
      cfg_bready_i = 0; cfg_rready_i = 0;

      // 6: asynchronous reset mid-count
      cfg_write(ADDR_DBNC, 32'd20);
      irq_raw_i[3] = 1'b1;
      tick(5);
      chk("t6_pre_irq", irq_o[0], 1);
      #2 rst_i = 1'b1;
      #1;
      chk("t6_async_irq", irq_o, 4'h0);
      repeat (2) @(posedge clk_i);
      #1 rst_i = 1'b0;
      tick();
      cfg_read(ADDR_CTRL, rd);
      chk("t6_ctrl", rd, 0);
      cfg_read(ADDR_DBNC, rd);
      chk("t6_dbnc", rd, 0);
      chk("t6_irq_after", irq_o, 4'h0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

endmodule
